// File: rtl/bp_pkg.sv
// Shared types and helpers for the fetch-stage branch predictor: 2-bit
// saturating counter encoding, reset/allocate values and the counter update.
package bp_pkg;

    typedef enum logic [1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        ST  = 2'b11
    } bp_ctr_t;

    localparam bp_ctr_t CTR_RESET = WNT;
    localparam bp_ctr_t CTR_ALLOC = WT;

    function automatic bp_ctr_t bp_ctr_next(input bp_ctr_t ctr, input logic taken);
        bp_ctr_t n;
        n = ctr;
        case (ctr)
            SNT:     n = taken ? WNT : SNT;
            WNT:     n = taken ? WT  : SNT;
            WT:      n = taken ? ST  : WNT;
            ST:      n = taken ? ST  : WT;
            default: n = ctr;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/bp_table.sv
// Direct-mapped predictor storage: per-entry valid/tag/target/counter with
// async reset, two combinational read ports (fetch, execute) and one write port.
module bp_table
    import bp_pkg::*;
#(
    parameter int INDEX_BITS = 4,
    parameter int TAG_W      = 26,
    parameter int PC_WIDTH   = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [INDEX_BITS-1:0] rd_idx_a,
    output logic                  rd_valid_a,
    output logic [TAG_W-1:0]      rd_tag_a,
    output logic [PC_WIDTH-1:0]   rd_target_a,
    output logic [1:0]            rd_ctr_a,
    input  logic [INDEX_BITS-1:0] rd_idx_b,
    output logic                  rd_valid_b,
    output logic [TAG_W-1:0]      rd_tag_b,
    output logic [PC_WIDTH-1:0]   rd_target_b,
    output logic [1:0]            rd_ctr_b,
    input  logic                  wr_en,
    input  logic [INDEX_BITS-1:0] wr_idx,
    input  logic [TAG_W-1:0]      wr_tag,
    input  logic [PC_WIDTH-1:0]   wr_target,
    input  logic [1:0]            wr_ctr
);

    localparam int ENTRIES = 1 << INDEX_BITS;

    logic                valid_q  [ENTRIES];
    logic [TAG_W-1:0]    tag_q    [ENTRIES];
    logic [PC_WIDTH-1:0] target_q [ENTRIES];
    bp_ctr_t             ctr_q    [ENTRIES];

    // Registers rather than a RAM: reset must clear every entry at once.
    for (genvar gi = 0; gi < ENTRIES; gi++) begin : g_entry
        logic                valid_reg;
        logic [TAG_W-1:0]    tag_reg;
        logic [PC_WIDTH-1:0] target_reg;
        bp_ctr_t             ctr_reg;

        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
                valid_reg  <= 1'b0;
                tag_reg    <= '0;
                target_reg <= '0;
                ctr_reg    <= CTR_RESET;
            end else if (wr_en && (wr_idx == INDEX_BITS'(gi))) begin
                valid_reg  <= 1'b1;
                tag_reg    <= wr_tag;
                target_reg <= wr_target;
                ctr_reg    <= bp_ctr_t'(wr_ctr);
            end
        end

        assign valid_q[gi]  = valid_reg;
        assign tag_q[gi]    = tag_reg;
        assign target_q[gi] = target_reg;
        assign ctr_q[gi]    = ctr_reg;
    end

    assign rd_valid_a  = valid_q[rd_idx_a];
    assign rd_tag_a    = tag_q[rd_idx_a];
    assign rd_target_a = target_q[rd_idx_a];
    assign rd_ctr_a    = ctr_q[rd_idx_a];

    assign rd_valid_b  = valid_q[rd_idx_b];
    assign rd_tag_b    = tag_q[rd_idx_b];
    assign rd_target_b = target_q[rd_idx_b];
    assign rd_ctr_b    = ctr_q[rd_idx_b];

endmodule

// File: rtl/branch_predictor_f.sv
// Fetch-stage direction/target predictor: zero-latency lookup on the fetch PC,
// training from resolved Execute branches, and branch/mispredict counters.
module branch_predictor_f
    import bp_pkg::*;
#(
    parameter int PC_WIDTH   = 32,
    parameter int INDEX_BITS = 4,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [PC_WIDTH-1:0]  PCF_i,
    output logic                 predictTakenF_o,
    output logic [PC_WIDTH-1:0]  predictPCF_o,
    input  logic                 branchE_i,
    input  logic [PC_WIDTH-1:0]  PCE_i,
    input  logic                 takenE_i,
    input  logic [PC_WIDTH-1:0]  targetE_i,
    input  logic                 predictTakenE_i,
    output logic [CNT_WIDTH-1:0] branchCount_o,
    output logic [CNT_WIDTH-1:0] mispredCount_o
);

    localparam int TAG_W = PC_WIDTH - INDEX_BITS - 2;

    logic [INDEX_BITS-1:0] f_idx;
    logic [TAG_W-1:0]      f_tag;
    logic                  f_valid;
    logic [TAG_W-1:0]      f_tag_q;
    logic [PC_WIDTH-1:0]   f_target;
    logic [1:0]            f_ctr;
    logic                  f_hit;

    logic [INDEX_BITS-1:0] e_idx;
    logic [TAG_W-1:0]      e_tag;
    logic                  e_valid;
    logic [TAG_W-1:0]      e_tag_q;
    logic [PC_WIDTH-1:0]   e_target;
    logic [1:0]            e_ctr;
    logic                  e_hit;

    logic                  wr_en;
    logic [PC_WIDTH-1:0]   wr_target;
    logic [1:0]            wr_ctr;

    logic [CNT_WIDTH-1:0]  branch_count_reg;
    logic [CNT_WIDTH-1:0]  branch_count_next;
    logic [CNT_WIDTH-1:0]  mispred_count_reg;
    logic [CNT_WIDTH-1:0]  mispred_count_next;

    // Instructions are word aligned, so the low two PC bits carry no information.
    logic unused_pc_bits;
    assign unused_pc_bits = ^{PCF_i[1:0], PCE_i[1:0]};

    assign f_idx = PCF_i[INDEX_BITS+1:2];
    assign f_tag = PCF_i[PC_WIDTH-1:INDEX_BITS+2];
    assign e_idx = PCE_i[INDEX_BITS+1:2];
    assign e_tag = PCE_i[PC_WIDTH-1:INDEX_BITS+2];

    bp_table #(
        .INDEX_BITS (INDEX_BITS),
        .TAG_W      (TAG_W),
        .PC_WIDTH   (PC_WIDTH)
    ) u_table (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .rd_idx_a    (f_idx),
        .rd_valid_a  (f_valid),
        .rd_tag_a    (f_tag_q),
        .rd_target_a (f_target),
        .rd_ctr_a    (f_ctr),
        .rd_idx_b    (e_idx),
        .rd_valid_b  (e_valid),
        .rd_tag_b    (e_tag_q),
        .rd_target_b (e_target),
        .rd_ctr_b    (e_ctr),
        .wr_en       (wr_en),
        .wr_idx      (e_idx),
        .wr_tag      (e_tag),
        .wr_target   (wr_target),
        .wr_ctr      (wr_ctr)
    );

    // Lookup reads the table as it stands; a same-cycle write is not bypassed.
    assign f_hit           = f_valid && (f_tag_q == f_tag);
    assign predictTakenF_o = f_hit && f_ctr[1];
    assign predictPCF_o    = predictTakenF_o ? f_target : (PCF_i + PC_WIDTH'(4));

    assign e_hit = e_valid && (e_tag_q == e_tag);

    // Hits train in place; only a taken miss is worth an entry.
    always_comb begin
        wr_en     = 1'b0;
        wr_target = e_target;
        wr_ctr    = e_ctr;
        if (branchE_i) begin
            if (e_hit) begin
                wr_en  = 1'b1;
                wr_ctr = bp_ctr_next(bp_ctr_t'(e_ctr), takenE_i);
                if (takenE_i) begin
                    wr_target = targetE_i;
                end
            end else if (takenE_i) begin
                wr_en     = 1'b1;
                wr_target = targetE_i;
                wr_ctr    = CTR_ALLOC;
            end
        end
    end

    always_comb begin
        branch_count_next  = branch_count_reg;
        mispred_count_next = mispred_count_reg;
        if (branchE_i) begin
            branch_count_next = branch_count_reg + CNT_WIDTH'(1);
            if (predictTakenE_i != takenE_i) begin
                mispred_count_next = mispred_count_reg + CNT_WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            branch_count_reg  <= '0;
            mispred_count_reg <= '0;
        end else begin
            branch_count_reg  <= branch_count_next;
            mispred_count_reg <= mispred_count_next;
        end
    end

    assign branchCount_o  = branch_count_reg;
    assign mispredCount_o = mispred_count_reg;

endmodule

// File: tb/tb_branch_predictor_f.sv
// Directed bench for branch_predictor_f: stimulus queues expected lookups and
// counters, a negedge monitor pops and compares against the DUT outputs.
module tb_branch_predictor_f;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic [31:0] PCF_i;
    logic        predictTakenF_o;
    logic [31:0] predictPCF_o;
    logic        branchE_i;
    logic [31:0] PCE_i;
    logic        takenE_i;
    logic [31:0] targetE_i;
    logic        predictTakenE_i;
    logic [31:0] branchCount_o;
    logic [31:0] mispredCount_o;

    logic        taken4;
    logic [31:0] pc4;
    logic [3:0]  bc4;
    logic [3:0]  mc4;

    always #5 clk_i = ~clk_i;

    branch_predictor_f dut (
        .clk_i           (clk_i),
        .rst_i           (rst_i),
        .PCF_i           (PCF_i),
        .predictTakenF_o (predictTakenF_o),
        .predictPCF_o    (predictPCF_o),
        .branchE_i       (branchE_i),
        .PCE_i           (PCE_i),
        .takenE_i        (takenE_i),
        .targetE_i       (targetE_i),
        .predictTakenE_i (predictTakenE_i),
        .branchCount_o   (branchCount_o),
        .mispredCount_o  (mispredCount_o)
    );

    // Narrow-counter copy sharing every input, used to observe counter wrap.
    branch_predictor_f #(.CNT_WIDTH(4)) dut4 (
        .clk_i           (clk_i),
        .rst_i           (rst_i),
        .PCF_i           (PCF_i),
        .predictTakenF_o (taken4),
        .predictPCF_o    (pc4),
        .branchE_i       (branchE_i),
        .PCE_i           (PCE_i),
        .takenE_i        (takenE_i),
        .targetE_i       (targetE_i),
        .predictTakenE_i (predictTakenE_i),
        .branchCount_o   (bc4),
        .mispredCount_o  (mc4)
    );

    typedef struct {
        string       name;
        logic        taken;
        logic [31:0] pc;
        logic [31:0] bc;
        logic [31:0] mc;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        cur;
    int          pass_cnt  = 0;
    int          total_cnt = 0;
    logic [31:0] bc_exp    = 0;
    logic [31:0] mc_exp    = 0;

    task automatic chk(input string nm, input string field,
                       input logic [31:0] act, input logic [31:0] req);
        total_cnt++;
        if (act === req) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s.%s: got 0x%0h, expected 0x%0h", nm, field, act, req);
        end
    endtask

    always @(negedge clk_i) begin
        while (exp_q.size() > 0) begin
            cur = exp_q.pop_front();
            $display("check %-14s pcf=0x%0h taken=%0b npc=0x%0h bc=%0d mc=%0d",
                     cur.name, PCF_i, predictTakenF_o, predictPCF_o,
                     branchCount_o, mispredCount_o);
            chk(cur.name, "taken",  {31'd0, predictTakenF_o}, {31'd0, cur.taken});
            chk(cur.name, "npc",    predictPCF_o,   cur.pc);
            chk(cur.name, "bcount", branchCount_o,  cur.bc);
            chk(cur.name, "mcount", mispredCount_o, cur.mc);
            chk(cur.name, "taken4", {31'd0, taken4}, {31'd0, cur.taken});
            chk(cur.name, "bcnt4",  {28'd0, bc4},   {28'd0, cur.bc[3:0]});
            chk(cur.name, "mcnt4",  {28'd0, mc4},   {28'd0, cur.mc[3:0]});
        end
    end

    // Advance one edge; the reference counters follow the inputs held across it.
    task automatic tick();
        @(posedge clk_i);
        if (!rst_i && branchE_i) begin
            bc_exp++;
            if (predictTakenE_i != takenE_i) mc_exp++;
        end
        #1;
    endtask

    task automatic drive(input logic br, input logic [31:0] pce, input logic tk,
                         input logic [31:0] tgt, input logic ptk, input logic [31:0] pcf);
        branchE_i       = br;
        PCE_i           = pce;
        takenE_i        = tk;
        targetE_i       = tgt;
        predictTakenE_i = ptk;
        PCF_i           = pcf;
    endtask

    task automatic expect_lookup(input string nm, input logic tk, input logic [31:0] npc);
        exp_t e;
        e.name  = nm;
        e.taken = tk;
        e.pc    = npc;
        e.bc    = bc_exp;
        e.mc    = mc_exp;
        exp_q.push_back(e);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_i = 1'b1;
        drive(0, 32'h0, 0, 32'h0, 0, 32'h100);
        expect_lookup("reset_held", 0, 32'h104);
        tick(); tick();
        rst_i = 1'b0;
        expect_lookup("reset_state", 0, 32'h104);
        tick();

        // Allocate 0x100 -> 0x80; same-cycle lookup must see the old table.
        drive(1, 32'h100, 1, 32'h80, 0, 32'h100);
        expect_lookup("alloc_nobyp", 0, 32'h104);
        tick();
        drive(0, 32'h0, 0, 32'h0, 0, 32'h100);
        expect_lookup("alloc_hit", 1, 32'h80);
        tick();

        // Hysteresis: WT -> WNT -> SNT -> WNT -> WT.
        drive(1, 32'h100, 0, 32'h0, 1, 32'h100);
        expect_lookup("hyst_wt", 1, 32'h80);
        tick();
        drive(1, 32'h100, 0, 32'h0, 0, 32'h100);
        expect_lookup("hyst_wnt", 0, 32'h104);
        tick();
        drive(1, 32'h100, 1, 32'h80, 0, 32'h100);
        expect_lookup("hyst_snt", 0, 32'h104);
        tick();
        drive(1, 32'h100, 1, 32'h80, 0, 32'h100);
        expect_lookup("hyst_wnt2", 0, 32'h104);
        tick();
        drive(0, 32'h0, 0, 32'h0, 0, 32'h100);
        expect_lookup("hyst_wt2", 1, 32'h80);
        tick();

        // Saturation: three taken to ST, one not-taken (with a decoy target) to WT.
        for (int i = 0; i < 3; i++) begin
            drive(1, 32'h100, 1, 32'h80, 1, 32'h100);
            tick();
        end
        drive(1, 32'h100, 0, 32'h300, 1, 32'h100);
        expect_lookup("sat_st", 1, 32'h80);
        tick();
        drive(0, 32'h0, 0, 32'h0, 0, 32'h100);
        expect_lookup("sat_back_wt", 1, 32'h80);
        tick();

        // Aliasing: 0x140 shares index 0 and replaces the entry.
        drive(1, 32'h140, 1, 32'h200, 0, 32'h100);
        tick();
        drive(0, 32'h0, 0, 32'h0, 0, 32'h100);
        expect_lookup("alias_old", 0, 32'h104);
        tick();
        drive(0, 32'h0, 0, 32'h0, 0, 32'h140);
        expect_lookup("alias_new", 1, 32'h200);
        tick();
        drive(1, 32'h180, 0, 32'h500, 0, 32'h140);
        tick();
        drive(0, 32'h0, 0, 32'h0, 0, 32'h140);
        expect_lookup("alias_ntmiss", 1, 32'h200);
        tick();
        drive(0, 32'h0, 0, 32'h0, 0, 32'h104);
        expect_lookup("other_index", 0, 32'h108);
        tick();

        // Five more branches bring the total to 16 so the 4-bit copy wraps.
        for (int i = 0; i < 5; i++) begin
            drive(1, 32'h180, 0, 32'h0, 0, 32'h140);
            tick();
        end
        drive(0, 32'h0, 0, 32'h0, 0, 32'h140);
        expect_lookup("wrap16", 1, 32'h200);
        tick();

        // Asynchronous reset between edges with a valid entry and a branch pending.
        drive(1, 32'h140, 1, 32'h200, 0, 32'h140);
        rst_i  = 1'b1;
        bc_exp = 0;
        mc_exp = 0;
        expect_lookup("async_rst", 0, 32'h144);
        tick();
        rst_i = 1'b0;
        drive(0, 32'h0, 0, 32'h0, 0, 32'h140);
        expect_lookup("post_rst", 0, 32'h144);
        tick();
        drive(1, 32'h140, 1, 32'h240, 1, 32'h140);
        tick();
        drive(0, 32'h0, 0, 32'h0, 0, 32'h140);
        expect_lookup("resume", 1, 32'h240);
        tick();

        @(negedge clk_i);
        #1;
        if (exp_q.size() != 0) begin
            total_cnt++;
            $display("FAIL drain: got %0d pending, expected 0", exp_q.size());
        end
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
